// File: rtl/buzzer_axi_lite_slave.sv
// AXI4-Lite slave for the buzzer peripheral: four 32-bit registers plus a
// square-wave tone generator that drives the buzzer pin.
module buzzer_axi_lite_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              buzzer_out,
    output logic                              buzzer_busy
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned NB       = DW / 8;
    localparam int unsigned NREG     = 4;
    localparam int unsigned IDX_W    = 2;
    localparam logic [IDX_W-1:0] REG_CTRL = IDX_W'(0);
    localparam logic [IDX_W-1:0] REG_HALF = IDX_W'(1);
    localparam logic [IDX_W-1:0] REG_BEEP = IDX_W'(2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TONE = 1'b1
    } state_e;

    logic                 clk;
    logic                 rst_n;
    assign clk   = s00_axi_aclk;
    assign rst_n = s00_axi_aresetn;

    // Protection bits and byte-lane address bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // ---------------------------------------------------------------- state
    logic                 awready_q, awready_d;
    logic                 aw_held_q, aw_held_d;
    logic [IDX_W-1:0]     aw_idx_q,  aw_idx_d;
    logic                 wready_q,  wready_d;
    logic                 w_held_q,  w_held_d;
    logic [DW-1:0]        w_data_q,  w_data_d;
    logic [NB-1:0]        w_strb_q,  w_strb_d;
    logic                 bvalid_q,  bvalid_d;
    logic                 arready_q, arready_d;
    logic                 rvalid_q,  rvalid_d;
    logic [DW-1:0]        rdata_q,   rdata_d;
    logic [DW-1:0]        regs_q [NREG];
    logic [DW-1:0]        regs_d [NREG];

    state_e               state_q,   state_d;
    logic [DW-1:0]        half_lat_q, half_lat_d;
    logic [DW-1:0]        half_cnt_q, half_cnt_d;
    logic [DW-1:0]        dur_cnt_q,  dur_cnt_d;
    logic                 out_q,      out_d;
    logic                 busy_q,     busy_d;

    logic                 aw_fire;
    logic                 w_fire;
    logic                 ar_fire;
    logic                 wr_commit;
    logic                 ctrl_wr;
    logic                 ctrl_start;

    assign aw_fire    = s00_axi_awvalid && awready_q;
    assign w_fire     = s00_axi_wvalid  && wready_q;
    assign ar_fire    = s00_axi_arvalid && arready_q;
    assign wr_commit  = aw_held_q && w_held_q;
    assign ctrl_wr    = wr_commit && (aw_idx_q == REG_CTRL);
    // Bit0 as it will read after the pending CTRL write lands.
    assign ctrl_start = w_strb_q[0] ? w_data_q[0] : regs_q[REG_CTRL][0];

    // ------------------------------------------------------- write channel
    always_comb begin
        awready_d = 1'b0;
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        wready_d  = 1'b0;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        for (int r = 0; r < int'(NREG); r++) begin
            regs_d[r] = regs_q[r];
        end

        if (s00_axi_awvalid && !aw_held_q && !awready_q && !bvalid_q) begin
            awready_d = 1'b1;
        end
        if (s00_axi_wvalid && !w_held_q && !wready_q && !bvalid_q) begin
            wready_d = 1'b1;
        end
        if (aw_fire) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s00_axi_awaddr[3:2];
        end
        if (w_fire) begin
            w_held_d = 1'b1;
            w_data_d = s00_axi_wdata;
            w_strb_d = s00_axi_wstrb;
        end

        if (wr_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            for (int b = 0; b < int'(NB); b++) begin
                if (w_strb_q[b]) begin
                    regs_d[aw_idx_q][b*8 +: 8] = w_data_q[b*8 +: 8];
                end
            end
        end else if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end
    end

    // -------------------------------------------------------- read channel
    always_comb begin
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (s00_axi_arvalid && !rvalid_q && !arready_q) begin
            arready_d = 1'b1;
        end
        // Sampled from the register array before any same-edge write lands.
        if (ar_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[s00_axi_araddr[3:2]];
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------ beep FSM
    always_comb begin
        state_d    = state_q;
        half_lat_d = half_lat_q;
        half_cnt_d = half_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        out_d      = out_q;

        case (state_q)
            ST_IDLE: begin
                out_d = 1'b0;
                if (ctrl_wr && ctrl_start) begin
                    state_d    = ST_TONE;
                    half_lat_d = regs_q[REG_HALF];
                    half_cnt_d = regs_q[REG_HALF];
                    dur_cnt_d  = regs_q[REG_BEEP];
                end
            end
            ST_TONE: begin
                if (ctrl_wr) begin
                    out_d = 1'b0;
                    if (ctrl_start) begin
                        half_lat_d = regs_q[REG_HALF];
                        half_cnt_d = regs_q[REG_HALF];
                        dur_cnt_d  = regs_q[REG_BEEP];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (dur_cnt_q == DW'(1)) begin
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                end else begin
                    // A zero duration count means a continuous tone.
                    if (dur_cnt_q != '0) begin
                        dur_cnt_d = dur_cnt_q - DW'(1);
                    end
                    if (half_cnt_q == '0) begin
                        out_d      = ~out_q;
                        half_cnt_d = half_lat_q;
                    end else begin
                        half_cnt_d = half_cnt_q - DW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                out_d   = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_TONE);
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            awready_q <= 1'b0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            wready_q  <= 1'b0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int r = 0; r < int'(NREG); r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            awready_q <= awready_d;
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            wready_q  <= wready_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            for (int r = 0; r < int'(NREG); r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            half_lat_q <= '0;
            half_cnt_q <= '0;
            dur_cnt_q  <= '0;
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_lat_q <= half_lat_d;
            half_cnt_q <= half_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign s00_axi_rvalid  = rvalid_q;
    assign buzzer_out      = out_q;
    assign buzzer_busy     = busy_q;

endmodule

// File: tb/tb_buzzer_axi_lite_slave.sv
// Scoreboard bench for buzzer_axi_lite_slave: queued B/R expectations plus a
// cycle-indexed tone model derived from the register contents.
module tb_buzzer_axi_lite_slave;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        buz_out;
    logic        buz_busy;

    always #5 clk = ~clk;

    buzzer_axi_lite_slave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .buzzer_out      (buz_out),
        .buzzer_busy     (buz_busy)
    );

    int          checks   = 0;
    int          failures = 0;
    longint      cyc      = 0;

    logic [31:0] model [4];
    logic [31:0] rq [$];
    logic [1:0]  bq [$];

    bit          tone_on  = 1'b0;
    bit          tone_ign = 1'b1;
    longint      tone_t0  = 0;
    longint      tone_h   = 0;
    longint      tone_n   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // B and R monitor: pop one expectation per completed handshake.
    always @(negedge clk) begin
        if (aresetn) begin
            if (bvalid && bready) begin
                checks++;
                if (bq.size() == 0) begin
                    failures++;
                    $display("FAIL bresp_unexpected got bvalid with no write outstanding");
                end else begin
                    logic [1:0] eb;
                    eb = bq.pop_front();
                    if (bresp !== eb) begin
                        failures++;
                        $display("FAIL bresp got=%b exp=%b", bresp, eb);
                    end
                end
            end
            if (rvalid && rready) begin
                checks++;
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL rdata_unexpected got rvalid with no read outstanding");
                end else begin
                    logic [31:0] er;
                    er = rq.pop_front();
                    if (rdata !== er || rresp !== 2'b00) begin
                        failures++;
                        $display("FAIL rdata got=%h resp=%b exp=%h resp=00", rdata, rresp, er);
                    end
                end
            end
        end
    end

    // Tone checker: expected waveform from cycles elapsed since the start write.
    always begin
        @(negedge clk);
        #1;
        if (!tone_ign) begin
            longint t;
            bit     act;
            bit     eo;
            t   = cyc - tone_t0;
            act = tone_on && (tone_n == 0 || t < tone_n);
            eo  = act && (((t / (tone_h + 1)) % 2) == 1);
            checks++;
            if (buz_out !== eo || buz_busy !== act) begin
                failures++;
                $display("FAIL tone t=%0d got out=%b busy=%b exp out=%b busy=%b",
                         t, buz_out, buz_busy, eo, act);
            end
        end
    end

    task automatic send_aw(input logic [3:0] a, input int dly);
        int n;
        repeat (dly) begin @(posedge clk); #1; end
        awaddr  = a;
        awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 64);
        checks++;
        if (!awready) begin
            failures++;
            $display("FAIL aw_timeout got awready=0 exp handshake within 64 cycles");
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        int n;
        repeat (dly) begin @(posedge clk); #1; end
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!wready && n < 64);
        checks++;
        if (!wready) begin
            failures++;
            $display("FAIL w_timeout got wready=0 exp handshake within 64 cycles");
        end
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int hold);
        logic [31:0] m;
        int          n;
        m = model[a[3:2]];
        for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
        model[a[3:2]] = m;
        bq.push_back(2'b00);
        if (hold > 0) bready = 1'b0;
        fork
            send_aw(a, aw_dly);
            send_w(d, s, w_dly);
        join
        n = 0;
        forever begin
            @(negedge clk);
            if (bvalid) break;
            n++;
            if (n > 64) break;
        end
        checks++;
        if (!bvalid) begin
            failures++;
            $display("FAIL bvalid_timeout got bvalid=0 exp response within 64 cycles");
        end else if (a[3:2] == 2'd0) begin
            tone_on = model[0][0];
            tone_t0 = cyc;
            tone_h  = longint'({32'd0, model[1]});
            tone_n  = longint'({32'd0, model[2]});
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            awaddr = 4'hC; awvalid = 1'b1;
            wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                checks++;
                if (!(bvalid && !awready && !wready)) begin
                    failures++;
                    $display("FAIL bhold got bvalid=%b awready=%b wready=%b exp 1 0 0",
                             bvalid, awready, wready);
                end
            end
            @(posedge clk); #1;
            awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [3:0] a);
        int n;
        rq.push_back(model[a[3:2]]);
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 64);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 64);
        checks++;
        if (!rvalid) begin
            failures++;
            $display("FAIL read_timeout got rvalid=0 exp read data within 64 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, buz_out, buz_busy} !== 7'd0
            || rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_%s got rdy/vld/buz=%b rdata=%h exp all zero", tag,
                     {awready, wready, bvalid, arready, rvalid, buz_out, buz_busy}, rdata);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        for (int r = 0; r < 4; r++) model[r] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("init");
        aresetn  = 1'b1;
        tone_ign = 1'b0;
        for (int r = 0; r < 4; r++) do_read(4'(r * 4));

        // Basic write/readback of all four registers.
        for (int r = 0; r < 4; r++) do_write(4'(r * 4), 32'(r + 1), 4'hF, 0, 0, 0);
        for (int r = 0; r < 4; r++) do_read(4'(r * 4));
        do_write(4'h0, 32'h0, 4'hF, 0, 0, 0);

        // AW/W skew in both directions.
        do_write(4'hC, 32'hA5A5_A5A5, 4'hF, 3, 0, 0);
        do_read(4'hC);
        do_write(4'hC, 32'h5A5A_5A5A, 4'hF, 0, 3, 0);
        do_read(4'hC);

        // Byte strobes, including an empty strobe.
        do_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_write(4'hC, 32'h0000_0012, 4'b0001, 0, 0, 0);
        do_read(4'hC);
        do_write(4'hC, 32'h1234_5678, 4'b0000, 1, 2, 0);
        do_read(4'hC);
        do_write(4'h8, 32'hAABB_CCDD, 4'b1010, 0, 0, 0);
        do_read(4'h8);

        // Finite beep with a 10-clock period.
        do_write(4'h4, 32'd4, 4'hF, 0, 0, 0);
        do_write(4'h8, 32'd50, 4'hF, 0, 0, 0);
        do_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
        repeat (70) @(posedge clk);
        #1;

        // Restart mid-tone; changed period only applies after restart.
        do_write(4'h4, 32'd2, 4'hF, 0, 0, 0);
        do_write(4'h8, 32'd40, 4'hF, 0, 0, 0);
        do_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
        do_write(4'h4, 32'd0, 4'hF, 0, 0, 0);
        repeat (7) @(posedge clk);
        #1;
        do_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
        repeat (45) @(posedge clk);
        #1;

        // Continuous tone then stop.
        do_write(4'h4, 32'd3, 4'hF, 0, 0, 0);
        do_write(4'h8, 32'd0, 4'hF, 0, 0, 0);
        do_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
        repeat (200) @(posedge clk);
        #1;
        do_write(4'h0, 32'd0, 4'hF, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1;

        // Randomized traffic, some with a concurrent read.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  a;
            logic [31:0] d;
            a = 4'($urandom_range(0, 3) * 4);
            d = $urandom;
            if (a == 4'h4 || a == 4'h8) d = 32'($urandom_range(0, 40));
            case ($urandom_range(0, 2))
                0: do_write(a, d, 4'($urandom_range(0, 15)),
                            $urandom_range(0, 3), $urandom_range(0, 3), 0);
                1: do_read(a);
                default: fork
                    do_write(4'hC, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 0, 0);
                    do_read(4'($urandom_range(0, 2) * 4));
                join
            endcase
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end
        do_write(4'h0, 32'd0, 4'hF, 0, 0, 0);

        // Response backpressure blocks new AW/W.
        do_write(4'hC, 32'h0BAD_F00D, 4'hF, 0, 0, 10);
        do_read(4'hC);

        // Reset in the middle of a tone.
        do_write(4'h4, 32'd3, 4'hF, 0, 0, 0);
        do_write(4'h8, 32'd0, 4'hF, 0, 0, 0);
        do_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2;
        aresetn  = 1'b0;
        tone_ign = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midtone");
        for (int r = 0; r < 4; r++) model[r] = '0;
        tone_on  = 1'b0;
        tone_ign = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        for (int r = 0; r < 4; r++) do_read(4'(r * 4));
        repeat (5) @(posedge clk);
        #1;

        checks++;
        if (bq.size() != 0 || rq.size() != 0) begin
            failures++;
            $display("FAIL leftover got b=%0d r=%0d pending exp 0 0", bq.size(), rq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
